simf_wb_sequencer: RTL and testbench
====================================

Name: simf_wb_sequencer

Overview:
- Writeback/retire stage for SIMF that consumes the per-instruction write enables produced by SIMF decode: out_vgpr_wr_en, out_sgpr_wr_en and out_vcc_wr_en.
- Buffers completed SIMF results in a small FIFO.
- Issues, in a fixed order, the VGPR write, the SGPR write (req/ack) and the VCC write, then pulses a retire to the wavepool/tracemon.
- Sits between the SIMF FP datapath output and the VGPR/SGPR/VCC write ports.

Parameters:
- FIFO_DEPTH, 4, result entries buffered; must be a power of 2, ≥2.
- LANES, 64, wavefront width (exec/compare mask bits).
- VGPR_DATA_W, 2048, LANES×32 packed write data.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  result valid from FP datapath.
- in_ready  out  1  FIFO can accept.
- in_wfid  in  6  wavefront id.
- in_pc  in  32  instruction PC.
- in_vgpr_wr_en  in  1  decoder VGPR enable.
- in_sgpr_wr_en  in  1  decoder SGPR enable.
- in_vcc_wr_en  in  1  decoder VCC enable.
- in_vgpr_dest_addr  in  10  VGPR destination.
- in_sgpr_dest_addr  in  9  SGPR destination (64-bit pair base).
- in_vgpr_data  in  VGPR_DATA_W  lane results.
- in_exec_mask  in  LANES  exec at issue.
- in_cmp_mask  in  LANES  per-lane compare result.
- out_vgpr_wr_en  out  1  VGPR write strobe.
- out_vgpr_dest_addr  out  10  VGPR address.
- out_vgpr_wr_data  out  VGPR_DATA_W  VGPR data.
- out_vgpr_wr_mask  out  LANES  lane mask (= exec).
- out_sgpr_req  out  1  SGPR write request.
- in_sgpr_ack  in  1  SGPR write accepted.
- out_sgpr_dest_addr  out  9  SGPR address.
- out_sgpr_wr_data  out  64  cmp_mask & exec_mask.
- out_vcc_wr_en  out  1  VCC write strobe.
- out_vcc_value  out  64  cmp_mask & exec_mask.
- out_retire  out  1  one-cycle retire pulse.
- out_retire_wfid  out  6  retiring wavefront.

Behaviour:
- Reset (rst==0 at posedge):
  - FIFO is emptied; FSM goes to IDLE.
  - All strobes (out_vgpr_wr_en, out_sgpr_req, out_vcc_wr_en, out_retire) are 0; all address/data outputs are 0.
  - in_ready is 1 from the first post-reset cycle.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full. There is no push-while-full, even with a same-cycle pop.
  - Pointers carry one extra wrap bit; full/empty are decided by pointer compare.
  - Pop occurs only in RETIRE.
- FSM states: IDLE, VGPR, SGPR, VCC, RETIRE.
  - IDLE: if not empty, go to the first enabled of VGPR→SGPR→VCC for the head entry; if none are enabled, go to RETIRE.
  - VGPR: one cycle; out_vgpr_wr_en=1 with head data/address/mask. Next state is the next enabled of SGPR/VCC, else RETIRE.
  - SGPR: out_sgpr_req held at 1 with stable addr/data until in_sgpr_ack is sampled 1. On that edge go to VCC if enabled, else RETIRE. An ack with req=0 is ignored.
  - VCC: one cycle; out_vcc_wr_en=1. Next state is RETIRE.
  - RETIRE: out_retire=1 with out_retire_wfid=head wfid; pop; go to IDLE.
- Outputs are decoded from state and the head entry; no write strobe is asserted outside its own state.
- Latency: an entry accepted into an empty FIFO at edge T:
  - VGPR-only: VGPR strobe in cycle T+2, retire pulse in T+3.
  - VOP3 compare with both SGPR and VCC enables and ack tied high: SGPR T+2, VCC T+3, retire T+4.
- An X on any input enable (decoder default case) is treated as 0 in synthesis.
- Reset mid-SGPR handshake: req drops at the reset edge; the partial instruction is discarded (no retire).

Optional Feature:
- Macro: SIMF_WB_TRACEMON_EN.
- Defined:
  - Adds output out_tracemon_retire_pc (32), valid on out_retire cycles.
  - Adds output out_tracemon_wr_cnt (3) = number of enables written for the retiring entry (0–3).
- Undefined: neither port exists; the FIFO does not store in_pc.

Decomposition:
- Shared package/include simf_wb_defs:
  - FSM state encodings (3-bit localparams).
  - FIFO entry field offsets.
  - SGPR address width.
  - VCC address constant 9'h06A for consistency checks.
- One sub-module: simf_wb_fifo (parameterised sync FIFO with wrap-bit pointers). The FSM stays in the top.

Test Plan:
- VGPR-only: push wfid=3, vgpr_dest=10'h010, data lane0=32'h3F800000 → out_vgpr_wr_en at T+2 with addr 0x010; out_retire at T+3 with wfid 3; no sgpr_req/vcc strobes.
- VOPC compare: vcc_wr_en=1, cmp=64'hFFFF_0000_FFFF_0000, exec=64'h0F0F_0F0F_0F0F_0F0F → out_vcc_value=64'h0F0F_0000_0F0F_0000 for exactly one cycle, then retire.
- SGPR backpressure: sgpr_wr_en=1, dest=9'h004, ack held low 5 cycles → req stays 1 with stable addr/data for 5 cycles; ack=1 → req falls next cycle; retire follows.
- FIFO full: push 4 entries while ack=0 → in_ready=0 after the 4th; the 5th in_valid is not accepted. Release ack → 4 retires in push order, wfids 0,1,2,3.
- No enables set (decoder default): entry retires at T+2 with no write strobes.
- Reset mid-SGPR handshake: rst=0 while req=1 → req=0, in_ready=1 next cycle, no retire for the aborted entry.

Source files
------------

// File: rtl/simf_wb_sequencer_pkg.sv
// Shared definitions for the SIMF writeback sequencer: FSM encodings, FIFO entry
// field offsets and address widths.
package simf_wb_defs;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VGPR   = 3'd1;
    localparam logic [2:0] ST_SGPR   = 3'd2;
    localparam logic [2:0] ST_VCC    = 3'd3;
    localparam logic [2:0] ST_RETIRE = 3'd4;

    localparam int WFID_W      = 6;
    localparam int PC_W        = 32;
    localparam int VGPR_ADDR_W = 10;
    localparam int SGPR_ADDR_W = 9;

    localparam logic [SGPR_ADDR_W-1:0] VCC_ADDR = 9'h06A;

    // Fixed-width header fields sit at the bottom of an entry; masks, lane data
    // and the optional PC follow and are placed by the top from its parameters.
    localparam int OFF_WFID      = 0;
    localparam int OFF_VGPR_EN   = OFF_WFID + WFID_W;
    localparam int OFF_SGPR_EN   = OFF_VGPR_EN + 1;
    localparam int OFF_VCC_EN    = OFF_SGPR_EN + 1;
    localparam int OFF_VGPR_ADDR = OFF_VCC_EN + 1;
    localparam int OFF_SGPR_ADDR = OFF_VGPR_ADDR + VGPR_ADDR_W;
    localparam int HDR_W         = OFF_SGPR_ADDR + SGPR_ADDR_W;

    // First write state still pending in VGPR -> SGPR -> VCC order, else RETIRE.
    function automatic logic [2:0] first_write_state(input logic vgpr_en,
                                                     input logic sgpr_en,
                                                     input logic vcc_en);
        logic [2:0] st;
        if (vgpr_en == 1'b1) begin
            st = ST_VGPR;
        end else if (sgpr_en == 1'b1) begin
            st = ST_SGPR;
        end else if (vcc_en == 1'b1) begin
            st = ST_VCC;
        end else begin
            st = ST_RETIRE;
        end
        return st;
    endfunction

endpackage

// File: rtl/simf_wb_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty come from pointer compare.
// Writes while full and reads while empty are ignored.
module simf_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array, not reset: contents are only observed behind a valid pointer.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/simf_wb_sequencer.sv
// SIMF writeback/retire sequencer: buffers results, then issues VGPR, SGPR (req/ack)
// and VCC writes in order and pulses retire. SIMF_WB_TRACEMON_EN adds tracemon ports.
module simf_wb_sequencer
    import simf_wb_defs::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int LANES       = 64,
    parameter int VGPR_DATA_W = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WFID_W-1:0]      in_wfid,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   in_vgpr_wr_en,
    input  logic                   in_sgpr_wr_en,
    input  logic                   in_vcc_wr_en,
    input  logic [VGPR_ADDR_W-1:0] in_vgpr_dest_addr,
    input  logic [SGPR_ADDR_W-1:0] in_sgpr_dest_addr,
    input  logic [VGPR_DATA_W-1:0] in_vgpr_data,
    input  logic [LANES-1:0]       in_exec_mask,
    input  logic [LANES-1:0]       in_cmp_mask,
    output logic                   out_vgpr_wr_en,
    output logic [VGPR_ADDR_W-1:0] out_vgpr_dest_addr,
    output logic [VGPR_DATA_W-1:0] out_vgpr_wr_data,
    output logic [LANES-1:0]       out_vgpr_wr_mask,
    output logic                   out_sgpr_req,
    input  logic                   in_sgpr_ack,
    output logic [SGPR_ADDR_W-1:0] out_sgpr_dest_addr,
    output logic [LANES-1:0]       out_sgpr_wr_data,
    output logic                   out_vcc_wr_en,
    output logic [LANES-1:0]       out_vcc_value,
`ifdef SIMF_WB_TRACEMON_EN
    output logic [PC_W-1:0]        out_tracemon_retire_pc,
    output logic [2:0]             out_tracemon_wr_cnt,
`endif
    output logic                   out_retire,
    output logic [WFID_W-1:0]      out_retire_wfid
);

    localparam int OFF_EXEC = HDR_W;
    localparam int OFF_CMP  = OFF_EXEC + LANES;
    localparam int OFF_DATA = OFF_CMP + LANES;
`ifdef SIMF_WB_TRACEMON_EN
    localparam int OFF_PC   = OFF_DATA + VGPR_DATA_W;
    localparam int ENTRY_W  = OFF_PC + PC_W;
`else
    localparam int ENTRY_W  = OFF_DATA + VGPR_DATA_W;
`endif

    logic [2:0]             state_r;
    logic [2:0]             state_next_s;
    logic [ENTRY_W-1:0]     push_entry_s;
    logic [ENTRY_W-1:0]     head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   push_s;
    logic                   pop_s;

    logic [WFID_W-1:0]      h_wfid_s;
    logic                   h_vgpr_en_s;
    logic                   h_sgpr_en_s;
    logic                   h_vcc_en_s;
    logic [VGPR_ADDR_W-1:0] h_vgpr_addr_s;
    logic [SGPR_ADDR_W-1:0] h_sgpr_addr_s;
    logic [LANES-1:0]       h_exec_s;
    logic [LANES-1:0]       h_cmp_s;
    logic [VGPR_DATA_W-1:0] h_data_s;
    logic [LANES-1:0]       h_masked_cmp_s;

`ifdef SIMF_WB_TRACEMON_EN
    assign push_entry_s = {in_pc, in_vgpr_data, in_cmp_mask, in_exec_mask,
                           in_sgpr_dest_addr, in_vgpr_dest_addr,
                           in_vcc_wr_en, in_sgpr_wr_en, in_vgpr_wr_en, in_wfid};
`else
    assign push_entry_s = {in_vgpr_data, in_cmp_mask, in_exec_mask,
                           in_sgpr_dest_addr, in_vgpr_dest_addr,
                           in_vcc_wr_en, in_sgpr_wr_en, in_vgpr_wr_en, in_wfid};
`endif

    assign in_ready = !fifo_full_s;
    assign push_s   = in_valid && !fifo_full_s;
    assign pop_s    = (state_r == ST_RETIRE);

    simf_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (push_entry_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign h_wfid_s       = head_s[OFF_WFID +: WFID_W];
    assign h_vgpr_en_s    = head_s[OFF_VGPR_EN];
    assign h_sgpr_en_s    = head_s[OFF_SGPR_EN];
    assign h_vcc_en_s     = head_s[OFF_VCC_EN];
    assign h_vgpr_addr_s  = head_s[OFF_VGPR_ADDR +: VGPR_ADDR_W];
    assign h_sgpr_addr_s  = head_s[OFF_SGPR_ADDR +: SGPR_ADDR_W];
    assign h_exec_s       = head_s[OFF_EXEC +: LANES];
    assign h_cmp_s        = head_s[OFF_CMP +: LANES];
    assign h_data_s       = head_s[OFF_DATA +: VGPR_DATA_W];
    assign h_masked_cmp_s = h_cmp_s & h_exec_s;

    // State register; reset abandons any in-flight handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: walk the head entry's enables in VGPR -> SGPR -> VCC order.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_next_s = first_write_state(h_vgpr_en_s, h_sgpr_en_s, h_vcc_en_s);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_VGPR: begin
                state_next_s = first_write_state(1'b0, h_sgpr_en_s, h_vcc_en_s);
            end
            ST_SGPR: begin
                if (in_sgpr_ack) begin
                    state_next_s = first_write_state(1'b0, 1'b0, h_vcc_en_s);
                end else begin
                    state_next_s = ST_SGPR;
                end
            end
            ST_VCC:    state_next_s = ST_RETIRE;
            ST_RETIRE: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: each strobe and its address/data are non-zero only in its own state.
    always_comb begin
        out_vgpr_wr_en     = 1'b0;
        out_vgpr_dest_addr = '0;
        out_vgpr_wr_data   = '0;
        out_vgpr_wr_mask   = '0;
        out_sgpr_req       = 1'b0;
        out_sgpr_dest_addr = '0;
        out_sgpr_wr_data   = '0;
        out_vcc_wr_en      = 1'b0;
        out_vcc_value      = '0;
        out_retire         = 1'b0;
        out_retire_wfid    = '0;
        case (state_r)
            ST_VGPR: begin
                out_vgpr_wr_en     = 1'b1;
                out_vgpr_dest_addr = h_vgpr_addr_s;
                out_vgpr_wr_data   = h_data_s;
                out_vgpr_wr_mask   = h_exec_s;
            end
            ST_SGPR: begin
                out_sgpr_req       = 1'b1;
                out_sgpr_dest_addr = h_sgpr_addr_s;
                out_sgpr_wr_data   = h_masked_cmp_s;
            end
            ST_VCC: begin
                out_vcc_wr_en      = 1'b1;
                out_vcc_value      = h_masked_cmp_s;
            end
            ST_RETIRE: begin
                out_retire         = 1'b1;
                out_retire_wfid    = h_wfid_s;
            end
            default: begin
                out_retire         = 1'b0;
            end
        endcase
    end

`ifdef SIMF_WB_TRACEMON_EN
    // Tracemon view of the retiring entry, zero outside the retire cycle.
    always_comb begin
        out_tracemon_retire_pc = '0;
        out_tracemon_wr_cnt    = 3'd0;
        if (state_r == ST_RETIRE) begin
            out_tracemon_retire_pc = head_s[OFF_PC +: PC_W];
            out_tracemon_wr_cnt    = {2'b00, h_vgpr_en_s} + {2'b00, h_sgpr_en_s}
                                   + {2'b00, h_vcc_en_s};
        end else begin
            out_tracemon_retire_pc = '0;
        end
    end
`endif

endmodule

// File: tb/tb_simf_wb_sequencer.sv
// Directed self-checking bench for simf_wb_sequencer (default parameters).
module tb_simf_wb_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_wfid;
    logic [31:0]   in_pc;
    logic          in_vgpr_wr_en;
    logic          in_sgpr_wr_en;
    logic          in_vcc_wr_en;
    logic [9:0]    in_vgpr_dest_addr;
    logic [8:0]    in_sgpr_dest_addr;
    logic [2047:0] in_vgpr_data;
    logic [63:0]   in_exec_mask;
    logic [63:0]   in_cmp_mask;
    logic          out_vgpr_wr_en;
    logic [9:0]    out_vgpr_dest_addr;
    logic [2047:0] out_vgpr_wr_data;
    logic [63:0]   out_vgpr_wr_mask;
    logic          out_sgpr_req;
    logic          in_sgpr_ack;
    logic [8:0]    out_sgpr_dest_addr;
    logic [63:0]   out_sgpr_wr_data;
    logic          out_vcc_wr_en;
    logic [63:0]   out_vcc_value;
    logic          out_retire;
    logic [5:0]    out_retire_wfid;
`ifdef SIMF_WB_TRACEMON_EN
    logic [31:0]   out_tracemon_retire_pc;
    logic [2:0]    out_tracemon_wr_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int retires;
    int idx;

    always #5 clk = ~clk;

    simf_wb_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_wfid            (in_wfid),
        .in_pc              (in_pc),
        .in_vgpr_wr_en      (in_vgpr_wr_en),
        .in_sgpr_wr_en      (in_sgpr_wr_en),
        .in_vcc_wr_en       (in_vcc_wr_en),
        .in_vgpr_dest_addr  (in_vgpr_dest_addr),
        .in_sgpr_dest_addr  (in_sgpr_dest_addr),
        .in_vgpr_data       (in_vgpr_data),
        .in_exec_mask       (in_exec_mask),
        .in_cmp_mask        (in_cmp_mask),
        .out_vgpr_wr_en     (out_vgpr_wr_en),
        .out_vgpr_dest_addr (out_vgpr_dest_addr),
        .out_vgpr_wr_data   (out_vgpr_wr_data),
        .out_vgpr_wr_mask   (out_vgpr_wr_mask),
        .out_sgpr_req       (out_sgpr_req),
        .in_sgpr_ack        (in_sgpr_ack),
        .out_sgpr_dest_addr (out_sgpr_dest_addr),
        .out_sgpr_wr_data   (out_sgpr_wr_data),
        .out_vcc_wr_en      (out_vcc_wr_en),
        .out_vcc_value      (out_vcc_value),
`ifdef SIMF_WB_TRACEMON_EN
        .out_tracemon_retire_pc (out_tracemon_retire_pc),
        .out_tracemon_wr_cnt    (out_tracemon_wr_cnt),
`endif
        .out_retire         (out_retire),
        .out_retire_wfid    (out_retire_wfid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [5:0] wfid, input logic v, input logic s, input logic c);
        in_wfid       = wfid;
        in_vgpr_wr_en = v;
        in_sgpr_wr_en = s;
        in_vcc_wr_en  = c;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_sgpr_ack = 1'b0; in_pc = 32'h0000_1000;
        set_entry(6'd0, 1'b0, 1'b0, 1'b0);
        in_vgpr_dest_addr = 10'h000; in_sgpr_dest_addr = 9'h000;
        in_vgpr_data = '0; in_exec_mask = 64'h0; in_cmp_mask = 64'h0;

        // Reset state
        tick(); tick();
        check("rst_vgpr_en", {63'd0, out_vgpr_wr_en}, 64'd0);
        check("rst_sgpr_req", {63'd0, out_sgpr_req}, 64'd0);
        check("rst_vcc_en", {63'd0, out_vcc_wr_en}, 64'd0);
        check("rst_retire", {63'd0, out_retire}, 64'd0);
        check("rst_sgpr_data", out_sgpr_wr_data, 64'd0);
        rst = 1'b1;
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // VGPR-only entry
        set_entry(6'd3, 1'b1, 1'b0, 1'b0);
        in_vgpr_dest_addr = 10'h010;
        in_exec_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        in_vgpr_data[31:0] = 32'h3F80_0000;
        in_vgpr_data[2047:2016] = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("vg_t1_idle", {63'd0, out_vgpr_wr_en}, 64'd0);
        tick();
        check("vg_t2_en", {63'd0, out_vgpr_wr_en}, 64'd1);
        check("vg_addr", {54'd0, out_vgpr_dest_addr}, 64'h010);
        check("vg_lane0", {32'd0, out_vgpr_wr_data[31:0]}, 64'h3F80_0000);
        check("vg_lane63", {32'd0, out_vgpr_wr_data[2047:2016]}, 64'hDEAD_BEEF);
        check("vg_mask", out_vgpr_wr_mask, 64'hFFFF_FFFF_FFFF_FFFF);
        check("vg_no_sgpr", {63'd0, out_sgpr_req}, 64'd0);
        check("vg_no_vcc", {63'd0, out_vcc_wr_en}, 64'd0);
        tick();
        check("vg_t3_retire", {63'd0, out_retire}, 64'd1);
        check("vg_retire_wfid", {58'd0, out_retire_wfid}, 64'd3);
        check("vg_t3_vgpr_off", {63'd0, out_vgpr_wr_en}, 64'd0);
        tick();
        check("vg_retire_once", {63'd0, out_retire}, 64'd0);

        // VOPC compare -> VCC only
        set_entry(6'd5, 1'b0, 1'b0, 1'b1);
        in_cmp_mask  = 64'hFFFF_0000_FFFF_0000;
        in_exec_mask = 64'h0F0F_0F0F_0F0F_0F0F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("vcc_t1_idle", {63'd0, out_vcc_wr_en}, 64'd0);
        tick();
        check("vcc_en", {63'd0, out_vcc_wr_en}, 64'd1);
        check("vcc_value", out_vcc_value, 64'h0F0F_0000_0F0F_0000);
        check("vcc_no_vgpr", {63'd0, out_vgpr_wr_en}, 64'd0);
        tick();
        check("vcc_one_cycle", {63'd0, out_vcc_wr_en}, 64'd0);
        check("vcc_retire", {63'd0, out_retire}, 64'd1);
        check("vcc_retire_wfid", {58'd0, out_retire_wfid}, 64'd5);
        tick();

        // SGPR backpressure: ack low for 5 cycles
        set_entry(6'd7, 1'b0, 1'b1, 1'b0);
        in_sgpr_dest_addr = 9'h004;
        in_cmp_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
        in_exec_mask = 64'h0000_0000_FFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        set_entry(6'd0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("sg_req_held", {63'd0, out_sgpr_req}, 64'd1);
            check("sg_addr", {55'd0, out_sgpr_dest_addr}, 64'h004);
            check("sg_data", out_sgpr_wr_data, 64'h0000_0000_FFFF_FFFF);
            check("sg_no_retire", {63'd0, out_retire}, 64'd0);
            if (i < 4) tick();
        end
        in_sgpr_ack = 1'b1;
        tick();
        in_sgpr_ack = 1'b0;
        check("sg_req_falls", {63'd0, out_sgpr_req}, 64'd0);
        check("sg_retire", {63'd0, out_retire}, 64'd1);
        check("sg_retire_wfid", {58'd0, out_retire_wfid}, 64'd7);
        tick();

        // VOP3 compare, SGPR + VCC with ack tied high (ack during IDLE is ignored)
        set_entry(6'd12, 1'b0, 1'b1, 1'b1);
        in_sgpr_dest_addr = 9'h020;
        in_cmp_mask  = 64'h0000_00FF_0000_00FF;
        in_exec_mask = 64'h0000_000F_0000_000F;
        in_sgpr_ack = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("v3_t1_idle", {63'd0, out_sgpr_req}, 64'd0);
        tick();
        check("v3_t2_sgpr", {63'd0, out_sgpr_req}, 64'd1);
        check("v3_sgpr_data", out_sgpr_wr_data, 64'h0000_000F_0000_000F);
        tick();
        check("v3_t3_vcc", {63'd0, out_vcc_wr_en}, 64'd1);
        check("v3_t3_req_off", {63'd0, out_sgpr_req}, 64'd0);
        check("v3_vcc_value", out_vcc_value, 64'h0000_000F_0000_000F);
        tick();
        check("v3_t4_retire", {63'd0, out_retire}, 64'd1);
        check("v3_retire_wfid", {58'd0, out_retire_wfid}, 64'd12);
        in_sgpr_ack = 1'b0;
        tick();

        // No enables: retire at T+2 with no writes
        set_entry(6'd21, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ne_t1_no_retire", {63'd0, out_retire}, 64'd0);
        tick();
        check("ne_t2_retire", {63'd0, out_retire}, 64'd1);
        check("ne_retire_wfid", {58'd0, out_retire_wfid}, 64'd21);
        check("ne_strobes", {61'd0, out_vgpr_wr_en, out_sgpr_req, out_vcc_wr_en}, 64'd0);
        tick();

        // FIFO full: four SGPR entries stall behind ack=0, fifth is refused
        in_sgpr_dest_addr = 9'h008;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ff_ready_before", {63'd0, in_ready}, 64'd1);
            set_entry(i[5:0], 1'b0, 1'b1, 1'b0);
            tick();
        end
        check("ff_full_ready", {63'd0, in_ready}, 64'd0);
        set_entry(6'd4, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        check("ff_still_full", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        in_sgpr_ack = 1'b1;
        retires = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_retire) begin
                check("ff_retire_order", {58'd0, out_retire_wfid}, retires[63:0]);
                retires++;
            end
            tick();
        end
        check("ff_retire_count", retires[63:0], 64'd4);
        check("ff_ready_after", {63'd0, in_ready}, 64'd1);
        in_sgpr_ack = 1'b0;

        // Reset mid-SGPR handshake
        set_entry(6'd9, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("rs_req_up", {63'd0, out_sgpr_req}, 64'd1);
        rst = 1'b0;
        tick();
        check("rs_req_drop", {63'd0, out_sgpr_req}, 64'd0);
        check("rs_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b1;
        in_sgpr_ack = 1'b1;
        retires = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_retire || out_sgpr_req) retires++;
        end
        check("rs_no_retire", retires[63:0], 64'd0);
        in_sgpr_ack = 1'b0;

        idx = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
